mem_arbiter: RTL and testbench

Arbitrates the single byte-wide RAM/IO port between the instruction cache and the data cache. Each requester runs a byte-serial, pipelined protocol: it presents one byte request per cycle and gets an acknowledge one cycle later. The data cache has priority at every grant decision. Once a requester owns the port, it keeps it until its request line drops, so a line fill or writeback is never interleaved. The block sits between both caches and the top-level RAM/HCI port, and it is gated by `hci_rdy`.

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares the single byte-wide RAM/IO port between the instruction
//             cache and the data cache. Each cache issues one byte request per
//             cycle and receives its acknowledge one cycle later. The dcache
//             wins every fresh grant decision, but an owner keeps the port
//             until it drops its request, so bursts are never interleaved.
//  Ports    : clk, rst            clock, synchronous active-high reset
//             hci_rdy             global enable; low freezes the arbiter
//             io_buffer_full      stalls accesses that target IO space
//             ic_get_en/ic_addr   icache byte request (read only)
//             ic_out_en/ic_content icache acknowledge and read byte
//             dc_get_en/dc_write_mode/dc_addr/dc_data  dcache byte request
//             dc_out_en/dc_content dcache acknowledge and read byte
//             ram_din             RAM/IO read data (one cycle after address)
//             ram_a/ram_dout/ram_wr  RAM/IO address, write data, write strobe
//             owner               current owner: 00 none, 01 icache, 10 dcache
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hci_rdy,
  input  logic        io_buffer_full,
  input  logic        ic_get_en,
  input  logic [17:0] ic_addr,
  output logic        ic_out_en,
  output logic [7:0]  ic_content,
  input  logic        dc_get_en,
  input  logic        dc_write_mode,
  input  logic [17:0] dc_addr,
  input  logic [7:0]  dc_data,
  output logic        dc_out_en,
  output logic [7:0]  dc_content,
  input  logic [7:0]  ram_din,
  output logic [17:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  output logic [1:0]  owner
);

  // The same encoding tags both the port owner and the pending response.
  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_IC   = 2'b01,
    OWN_DC   = 2'b10
  } owner_t;

  owner_t      r_owner;
  owner_t      w_owner_nxt;
  owner_t      w_serve;
  owner_t      r_pend;
  logic        r_pend_wr;
  logic        r_held;      // a response was parked while hci_rdy was low
  logic [7:0]  r_hold;
  logic        w_run;
  logic        w_stall;
  logic        w_issue;
  logic        w_ack;
  logic [17:0] w_addr;
  logic [7:0]  w_rdata;

  assign w_run = !rst && hci_rdy;

  // --------------------------------------------------------------------------
  // Owner FSM. The grant is purely combinational so that a handover happens
  // in the very cycle the previous owner drops its request. The cycle that
  // delivers a parked response issues nothing and keeps the owner.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_IDLE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_serve     = OWN_IDLE;
    w_owner_nxt = r_owner;
    if (w_run && !r_held) begin
      if (r_owner == OWN_IC && ic_get_en) begin
        w_serve = OWN_IC;
      end else if (r_owner == OWN_DC && dc_get_en) begin
        w_serve = OWN_DC;
      end else if (dc_get_en) begin
        w_serve = OWN_DC;
      end else if (ic_get_en) begin
        w_serve = OWN_IC;
      end
      // A stalled requester is still the one served, so it keeps ownership.
      w_owner_nxt = w_serve;
    end
  end

  // --------------------------------------------------------------------------
  // Access issue towards the RAM/IO port.
  // --------------------------------------------------------------------------
  always_comb begin
    w_addr = '0;
    case (w_serve)
      OWN_IC:  w_addr = ic_addr;
      OWN_DC:  w_addr = dc_addr;
      default: w_addr = '0;
    endcase
    w_stall  = (w_serve != OWN_IDLE) && (w_addr[17:16] == IO_SEL) && io_buffer_full;
    w_issue  = (w_serve != OWN_IDLE) && !w_stall;
    ram_a    = w_issue ? w_addr : '0;
    ram_wr   = w_issue && (w_serve == OWN_DC) && dc_write_mode;
    ram_dout = (w_issue && (w_serve == OWN_DC)) ? dc_data : '0;
  end

  // --------------------------------------------------------------------------
  // Response pipeline. While hci_rdy is low, ram_din of the outstanding
  // access is parked in r_hold because the RAM may present other data by the
  // time the acknowledge can be delivered.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend    <= OWN_IDLE;
      r_pend_wr <= 1'b0;
      r_held    <= 1'b0;
      r_hold    <= '0;
    end else if (!hci_rdy) begin
      if (r_pend != OWN_IDLE && !r_held) begin
        r_held <= 1'b1;
        r_hold <= ram_din;
      end
    end else if (r_held) begin
      r_pend <= OWN_IDLE;
      r_held <= 1'b0;
    end else begin
      r_pend    <= w_issue ? w_serve : OWN_IDLE;
      r_pend_wr <= ram_wr;
    end
  end

  assign w_ack      = w_run && (r_pend != OWN_IDLE);
  assign w_rdata    = r_pend_wr ? 8'h00 : (r_held ? r_hold : ram_din);
  assign ic_out_en  = w_ack && (r_pend == OWN_IC);
  assign dc_out_en  = w_ack && (r_pend == OWN_DC);
  assign ic_content = ic_out_en ? w_rdata : 8'h00;
  assign dc_content = dc_out_en ? w_rdata : 8'h00;
  assign owner      = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A RAM responder, two
//             burst requesters and a transaction-level reference model
//             (queue of outstanding accesses) run alongside the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam logic [1:0] C_IO_SEL = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hci_rdy = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic        ic_get_en = 1'b0;
  logic [17:0] ic_addr = '0;
  logic        ic_out_en;
  logic [7:0]  ic_content;
  logic        dc_get_en = 1'b0;
  logic        dc_write_mode = 1'b0;
  logic [17:0] dc_addr = '0;
  logic [7:0]  dc_data = '0;
  logic        dc_out_en;
  logic [7:0]  dc_content;
  logic [7:0]  ram_din;
  logic [17:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [1:0]  owner;

  always #5 clk = ~clk;

  mem_arbiter #(.IO_SEL(C_IO_SEL)) dut (
    .clk(clk), .rst(rst), .hci_rdy(hci_rdy), .io_buffer_full(io_buffer_full),
    .ic_get_en(ic_get_en), .ic_addr(ic_addr), .ic_out_en(ic_out_en), .ic_content(ic_content),
    .dc_get_en(dc_get_en), .dc_write_mode(dc_write_mode), .dc_addr(dc_addr), .dc_data(dc_data),
    .dc_out_en(dc_out_en), .dc_content(dc_content),
    .ram_din(ram_din), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .owner(owner)
  );

  // ---------------------------------------------------------------- memory
  function automatic logic [11:0] midx(input logic [17:0] a);
    return {a[17:16], a[9:0]};
  endfunction

  function automatic logic [7:0] init_byte(input logic [11:0] i);
    return i[7:0] ^ {2'b00, i[11:6]} ^ 8'h5A;
  endfunction

  logic [7:0] ram_mem [0:4095];
  logic [7:0] ref_mem [0:4095];

  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] = init_byte(12'(i));
    ram_mem[12'h104] = 8'hA5;
    ram_din = '0;
    forever begin
      @(posedge clk);
      ram_din <= ram_mem[midx(ram_a)];
      if (ram_wr) ram_mem[midx(ram_a)] = ram_dout;
    end
  end

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------- requesters
  bit          ic_act = 0, dc_act = 0, dc_wr = 0;
  int          ic_len = 0, dc_len = 0, ic_ack = 0, dc_ack = 0;
  logic [17:0] ic_base = '0, dc_base = '0;
  logic [7:0]  dc_seed = '0;
  logic [7:0]  dc_rx[$];
  logic [1:0]  own_log[$];

  task automatic start_ic(input logic [17:0] base, input int len);
    ic_base = base; ic_len = len; ic_ack = 0; ic_act = 1;
  endtask

  task automatic start_dc(input logic [17:0] base, input int len, input bit wr, input logic [7:0] seed);
    dc_base = base; dc_len = len; dc_ack = 0; dc_wr = wr; dc_seed = seed; dc_act = 1;
  endtask

  task automatic drive_reqs();
    ic_get_en     = ic_act;
    ic_addr       = ic_act ? ic_base + 18'(ic_ack) : '0;
    dc_get_en     = dc_act;
    dc_addr       = dc_act ? dc_base + 18'(dc_ack) : '0;
    dc_write_mode = dc_act && dc_wr;
    dc_data       = dc_act ? dc_seed + 8'(dc_ack) : '0;
  endtask

  // ---------------------------------------------------------------- reference model
  typedef struct {
    logic [1:0] who;
    logic [7:0] data;
    bit         deferred;
  } acc_t;

  acc_t       m_q[$];
  logic [1:0] m_owner = 2'b00;
  bit         m_valid = 0;

  task automatic model_check();
    logic [1:0]  nxt, serve;
    logic [17:0] a, e_a;
    logic [7:0]  e_ic_c, e_dc_c, e_do, rd;
    bit          e_ic_oe, e_dc_oe, e_wr, blk;
    e_ic_oe = 0; e_dc_oe = 0; e_wr = 0; e_a = '0;
    e_ic_c = '0; e_dc_c = '0; e_do = '0; rd = '0;
    nxt = m_owner;
    if (rst) begin
      m_q.delete();
      nxt = 2'b00;
    end else if (!hci_rdy) begin
      if (m_q.size() > 0) m_q[0].deferred = 1;
    end else begin
      blk = 0;
      if (m_q.size() > 0) begin
        if (m_q[0].who == 2'd1) begin e_ic_oe = 1; e_ic_c = m_q[0].data; end
        else begin e_dc_oe = 1; e_dc_c = m_q[0].data; end
        blk = m_q[0].deferred;
        void'(m_q.pop_front());
      end
      if (!blk) begin
        serve = 2'd0;
        if (m_owner == 2'd1 && ic_get_en)      serve = 2'd1;
        else if (m_owner == 2'd2 && dc_get_en) serve = 2'd2;
        else if (dc_get_en)                    serve = 2'd2;
        else if (ic_get_en)                    serve = 2'd1;
        nxt = serve;
        if (serve != 2'd0) begin
          a = (serve == 2'd2) ? dc_addr : ic_addr;
          if (!(a[17:16] == C_IO_SEL && io_buffer_full)) begin
            e_a = a;
            if (serve == 2'd2 && dc_write_mode) begin
              e_wr = 1;
              ref_mem[midx(a)] = dc_data;
              rd = 8'h00;
            end else begin
              rd = ref_mem[midx(a)];
            end
            if (serve == 2'd2) e_do = dc_data;
            m_q.push_back('{who: serve, data: rd, deferred: 1'b0});
          end
        end
      end
    end
    if (m_valid) begin
      chk("owner",      32'(owner),      32'(m_owner));
      chk("ram_a",      32'(ram_a),      32'(e_a));
      chk("ram_wr",     32'(ram_wr),     32'(e_wr));
      chk("ram_dout",   32'(ram_dout),   32'(e_do));
      chk("ic_out_en",  32'(ic_out_en),  32'(e_ic_oe));
      chk("ic_content", 32'(ic_content), 32'(e_ic_c));
      chk("dc_out_en",  32'(dc_out_en),  32'(e_dc_oe));
      chk("dc_content", 32'(dc_content), 32'(e_dc_c));
    end
    m_owner = nxt;
    if (rst) m_valid = 1;
  endtask

  // One clock cycle: control inputs, requester reaction to acknowledges,
  // then the model comparison well away from the clock edge.
  task automatic step(input bit r, input bit rdy, input bit iobf);
    @(posedge clk);
    #1;
    rst = r; hci_rdy = rdy; io_buffer_full = iobf;
    #1;
    if (r) begin
      ic_act = 0; dc_act = 0;
    end else begin
      if (ic_out_en && ic_act) begin
        ic_ack++;
        if (ic_ack == ic_len) ic_act = 0;
      end
      if (dc_out_en && dc_act) begin
        dc_rx.push_back(dc_content);
        dc_ack++;
        if (dc_ack == dc_len) dc_act = 0;
      end
    end
    drive_reqs();
    #1;
    model_check();
    own_log.push_back(owner);
  endtask

  task automatic run_idle(input int bound, output int n);
    n = 0;
    while ((ic_act || dc_act) && n < bound) begin
      step(0, 1, 0);
      n++;
    end
    chk("drain_busy", {30'b0, ic_act, dc_act}, 32'd0);
    ic_act = 0; dc_act = 0;
  endtask

  function automatic logic [17:0] rand_addr();
    logic [17:0] a;
    a = 18'($urandom);
    a[17:16] = ($urandom_range(0, 3) == 0) ? C_IO_SEL : 2'b00;
    return a;
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    logic [1:0] exp_seq [0:4];
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(12'(i));
    ref_mem[12'h104] = 8'hA5;

    step(1, 0, 0);
    step(1, 1, 0);
    step(0, 1, 0);

    // Single read
    dc_rx.delete();
    start_dc(18'h00104, 1, 0, 8'h00);
    run_idle(20, n);
    chk("single_cycles", 32'(n), 32'd2);
    chk("single_rx_cnt", 32'(dc_rx.size()), 32'd1);
    if (dc_rx.size() > 0) chk("single_data", 32'(dc_rx[0]), 32'hA5);

    // Contention: dcache line fill first, icache follows with no bubble
    own_log.delete();
    start_dc(18'h00200, 4, 0, 8'h00);
    start_ic(18'h01000, 1);
    run_idle(20, n);
    chk("contention_cycles", 32'(n), 32'd6);
    if (own_log.size() == 6)
      for (int i = 0; i < 5; i++) chk("contention_owner", 32'(own_log[i+1]), 32'(exp_seq[i]));
    else
      chk("contention_log", 32'(own_log.size()), 32'd6);

    // No preemption of an icache burst
    start_ic(18'h01040, 4);
    step(0, 1, 0);
    step(0, 1, 0);
    start_dc(18'h00220, 2, 0, 8'h00);
    run_idle(20, n);
    chk("nopreempt_cycles", 32'(n + 2), 32'd7);

    // IO stall on a dcache write
    start_dc(18'h30000, 1, 1, 8'h41);
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    run_idle(20, n);
    chk("iostall_cycles", 32'(n + 3), 32'd5);
    step(0, 1, 0);
    chk("iostall_mem", 32'(ram_mem[midx(18'h30000)]), 32'h41);

    // hci_rdy drop mid burst
    dc_rx.delete();
    start_dc(18'h00300, 4, 0, 8'h00);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    run_idle(20, n);
    chk("hci_cycles", 32'(n + 4), 32'd8);
    chk("hci_rx_cnt", 32'(dc_rx.size()), 32'd4);
    if (dc_rx.size() == 4)
      for (int i = 0; i < 4; i++) chk("hci_data", 32'(dc_rx[i]), 32'(init_byte(12'h300 + 12'(i))));

    // Reset mid burst
    dc_rx.delete();
    start_dc(18'h00400, 4, 0, 8'h00);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    chk("reset_rx_cnt", 32'(dc_rx.size()), 32'd1);
    chk("reset_owner", 32'(owner), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      if (!ic_act && $urandom_range(0, 3) == 0)
        start_ic(rand_addr(), int'($urandom_range(1, 4)));
      if (!dc_act && $urandom_range(0, 3) == 0)
        start_dc(rand_addr(), int'($urandom_range(1, 4)), bit'($urandom_range(0, 1)), 8'($urandom));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0));
    end
    run_idle(80, n);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
